// File: rtl/encrypter_loader_if.sv
// encrypter_loader_if
//   Bundles the byte-stream handshake, the two encrypter input-RAM write
//   ports and the encrypter start/done handshake of encrypter_loader.
//   slave  : view of the loader (consumes the stream, drives RAM writes)
//   master : view of the environment (produces the stream, sees RAM writes)
// Signals:
//   in_data[7:0], in_valid, in_last, in_ready     byte stream
//   input1_dia[31:0], input1_wea, input1_addra[4:0]  word RAM write port
//   input2_dia[7:0], input2_wea, input2_addra[9:0]   byte RAM write port
//   enc_start, enc_done                           encrypter handshake
//   job_done, frame_err                           job status pulses
interface encrypter_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] input1_dia;
  logic        input1_wea;
  logic [4:0]  input1_addra;
  logic [7:0]  input2_dia;
  logic        input2_wea;
  logic [9:0]  input2_addra;
  logic        enc_start;
  logic        enc_done;
  logic        job_done;
  logic        frame_err;

  modport slave (
    input  in_data, in_valid, in_last, enc_done,
    output in_ready,
    output input1_dia, input1_wea, input1_addra,
    output input2_dia, input2_wea, input2_addra,
    output enc_start, job_done, frame_err
  );

  modport master (
    output in_data, in_valid, in_last, enc_done,
    input  in_ready,
    input  input1_dia, input1_wea, input1_addra,
    input  input2_dia, input2_wea, input2_addra,
    input  enc_start, job_done, frame_err
  );
endinterface

// File: rtl/encrypter_loader.sv
// encrypter_loader
//   Upstream feeder for the encrypter. Takes one job as a byte stream:
//   POLY_BYTES pk polynomial bytes, SEED_BYTES pk seed bytes, SEED_BYTES
//   coin bytes, SEED_BYTES message bytes. Poly bytes go to the byte RAM
//   (input2); seed/coin/m are packed big-endian into 32-bit words for the
//   word RAM (input1). After the last m byte it pulses enc_start and holds
//   off further input until enc_done.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   encrypter_loader_if.slave (stream, RAM write ports, handshakes)
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | no job in flight; first accepted byte is pk byte 0
// S_LOAD_PK   | pk poly bytes -> input2 at address = byte index
// S_LOAD_SEED | pk seed bytes -> input1 words SEED_BYTES/4 ..
// S_LOAD_COIN | coin bytes    -> input1 words 0 ..
// S_LOAD_M    | m bytes       -> input1 words SEED_BYTES/2 ..
// S_START     | one-cycle enc_start pulse is being issued
// S_WAIT      | waiting for enc_done, stream blocked
module encrypter_loader #(
  parameter int POLY_BYTES = 896,
  parameter int SEED_BYTES = 32
) (
  input logic               clk,
  input logic               rst,
  encrypter_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_PK,
    S_LOAD_SEED,
    S_LOAD_COIN,
    S_LOAD_M,
    S_START,
    S_WAIT
  } state_t;

  localparam logic [9:0] PK_LAST   = 10'(POLY_BYTES - 1);
  localparam logic [9:0] SEG_LAST  = 10'(SEED_BYTES - 1);
  localparam logic [4:0] COIN_BASE = 5'd0;
  localparam logic [4:0] SEED_BASE = 5'(SEED_BYTES / 4);
  localparam logic [4:0] M_BASE    = 5'(SEED_BYTES / 2);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [23:0] pack_q, pack_d;
  logic        ready_q, ready_d;

  logic [31:0] i1_dia_q, i1_dia_d;
  logic        i1_wea_q, i1_wea_d;
  logic [4:0]  i1_addr_q, i1_addr_d;
  logic [7:0]  i2_dia_q, i2_dia_d;
  logic        i2_wea_q, i2_wea_d;
  logic [9:0]  i2_addr_q, i2_addr_d;

  logic        start_q, start_d;
  logic        job_done_q, job_done_d;
  logic        frame_err_q, frame_err_d;

  logic        accept;
  logic        seg_end;
  logic        job_end;
  logic [4:0]  word_base;
  logic [4:0]  word_addr;

  // in_ready is a registered copy of "next state is a loading state", so it
  // is low during reset and rises on the first edge after release.
  assign accept    = bus.in_valid && ready_q;
  assign seg_end   = (cnt_q == SEG_LAST);
  // The final byte of a job is the last m byte.
  assign job_end   = (state_q == S_LOAD_M) && seg_end;
  assign word_base = (state_q == S_LOAD_SEED) ? SEED_BASE :
                     (state_q == S_LOAD_COIN) ? COIN_BASE : M_BASE;
  assign word_addr = word_base + 5'(cnt_q[9:2]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    i1_dia_d    = i1_dia_q;
    i1_addr_d   = i1_addr_q;
    i1_wea_d    = 1'b0;
    i2_dia_d    = i2_dia_q;
    i2_addr_d   = i2_addr_q;
    i2_wea_d    = 1'b0;
    start_d     = 1'b0;
    job_done_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      // IDLE behaves as LOAD_PK at index 0: cnt is always 0 on entry to IDLE.
      S_IDLE, S_LOAD_PK: begin
        if (accept) begin
          if (bus.in_last) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
            cnt_d       = '0;
            pack_d      = '0;
          end else begin
            i2_wea_d  = 1'b1;
            i2_dia_d  = bus.in_data;
            i2_addr_d = cnt_q;
            if (cnt_q == PK_LAST) begin
              state_d = S_LOAD_SEED;
              cnt_d   = '0;
            end else begin
              state_d = S_LOAD_PK;
              cnt_d   = cnt_q + 10'd1;
            end
          end
        end
      end

      S_LOAD_SEED, S_LOAD_COIN, S_LOAD_M: begin
        if (accept) begin
          if (bus.in_last && !job_end) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
            cnt_d       = '0;
            pack_d      = '0;
          end else begin
            pack_d = {pack_q[15:0], bus.in_data};
            // Groups are aligned to the segment start, so the low counter
            // bits give the byte position within the word.
            if (cnt_q[1:0] == 2'd3) begin
              i1_wea_d  = 1'b1;
              i1_dia_d  = {pack_q, bus.in_data};
              i1_addr_d = word_addr;
            end
            if (seg_end) begin
              cnt_d  = '0;
              pack_d = '0;
              if (state_q == S_LOAD_SEED) begin
                state_d = S_LOAD_COIN;
              end else if (state_q == S_LOAD_COIN) begin
                state_d = S_LOAD_M;
              end else if (bus.in_last) begin
                state_d = S_START;
              end else begin
                // Full-length job without a terminator: data is written
                // but the job is dropped.
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
              end
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
        end
      end

      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT;
      end

      // enc_done is a level; if it is already high the job completes at once.
      S_WAIT: begin
        if (bus.enc_done) begin
          job_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pack_d  = '0;
      end
    endcase

    ready_d = state_d inside {S_IDLE, S_LOAD_PK, S_LOAD_SEED, S_LOAD_COIN, S_LOAD_M};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pack_q      <= '0;
      ready_q     <= 1'b0;
      i1_dia_q    <= '0;
      i1_wea_q    <= 1'b0;
      i1_addr_q   <= '0;
      i2_dia_q    <= '0;
      i2_wea_q    <= 1'b0;
      i2_addr_q   <= '0;
      start_q     <= 1'b0;
      job_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      ready_q     <= ready_d;
      i1_dia_q    <= i1_dia_d;
      i1_wea_q    <= i1_wea_d;
      i1_addr_q   <= i1_addr_d;
      i2_dia_q    <= i2_dia_d;
      i2_wea_q    <= i2_wea_d;
      i2_addr_q   <= i2_addr_d;
      start_q     <= start_d;
      job_done_q  <= job_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready     = ready_q;
  assign bus.input1_dia   = i1_dia_q;
  assign bus.input1_wea   = i1_wea_q;
  assign bus.input1_addra = i1_addr_q;
  assign bus.input2_dia   = i2_dia_q;
  assign bus.input2_wea   = i2_wea_q;
  assign bus.input2_addra = i2_addr_q;
  assign bus.enc_start    = start_q;
  assign bus.job_done     = job_done_q;
  assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_encrypter_loader.sv
// Testbench for encrypter_loader: table of job scenarios, hand-written
// handshake and async-reset sequences, and random jobs, all checked against
// a byte-stream reference model.
module tb_encrypter_loader;
  localparam int POLY = 896;
  localparam int SEED = 32;
  localparam int JOB  = POLY + 3 * SEED;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int gap_every;
    int gap_len;
    int bad_idx;
    bit omit_last;
    bit spot;
    int exp_i2;
    int exp_i1;
    int exp_start;
    int exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  encrypter_loader_if bus ();

  encrypter_loader #(.POLY_BYTES(POLY), .SEED_BYTES(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wr_t act_i1[$];
  wr_t act_i2[$];
  wr_t exp_i1[$];
  wr_t exp_i2[$];
  int start_cnt = 0, err_cnt = 0, done_cnt = 0, dbl_start = 0;
  int start_cyc = 0, last_i1_cyc = 0, ready_low = 0;
  logic prev_start = 1'b0;

  logic [7:0] s_data[$];
  bit         s_last[$];
  int m_start, m_err;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst === 1'b0) begin
      if (bus.input2_wea) act_i2.push_back('{int'(bus.input2_addra), 32'(bus.input2_dia)});
      if (bus.input1_wea) begin
        act_i1.push_back('{int'(bus.input1_addra), bus.input1_dia});
        last_i1_cyc = cyc;
      end
      if (bus.enc_start) begin
        start_cnt++;
        start_cyc = cyc;
        if (prev_start) dbl_start++;
      end
      if (bus.frame_err) err_cnt++;
      if (bus.job_done) done_cnt++;
      prev_start = bus.enc_start;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_mon();
    act_i1.delete();
    act_i2.delete();
    start_cnt = 0; err_cnt = 0; done_cnt = 0; dbl_start = 0;
    ready_low = 0; prev_start = 1'b0;
  endtask

  function automatic logic [7:0] pat(int i);
    if (i < POLY + SEED) return i[7:0];
    else if (i < POLY + 2 * SEED) return 8'(i - POLY - SEED);
    else return 8'(224 + i - POLY - 2 * SEED);
  endfunction

  task automatic build(int bad_idx, bit omit_last, bit rnd);
    int len;
    len = (bad_idx >= 0) ? bad_idx + 1 : JOB;
    s_data.delete();
    s_last.delete();
    for (int i = 0; i < len; i++) begin
      s_data.push_back(rnd ? 8'($urandom) : pat(i));
      s_last.push_back((bad_idx >= 0) ? (i == bad_idx) : (!omit_last && i == JOB - 1));
    end
  endtask

  // Reference: poly bytes land at their own index; each aligned group of
  // four seed/coin/m bytes becomes one big-endian word in that segment's
  // word range; a terminator anywhere but the final byte discards the rest.
  task automatic model();
    int j, seg, off, base;
    exp_i1.delete();
    exp_i2.delete();
    m_start = 0;
    m_err   = 0;
    for (int i = 0; i < s_data.size(); i++) begin
      if (s_last[i] && i != JOB - 1) begin
        m_err = 1;
        return;
      end
      if (i < POLY) begin
        exp_i2.push_back('{i, 32'(s_data[i])});
      end else begin
        j    = i - POLY;
        seg  = j / SEED;
        off  = j % SEED;
        base = (seg == 0) ? SEED / 4 : (seg == 1) ? 0 : SEED / 2;
        if (off % 4 == 3)
          exp_i1.push_back('{base + off / 4, {s_data[i-3], s_data[i-2], s_data[i-1], s_data[i]}});
      end
      if (i == JOB - 1) begin
        if (s_last[i]) m_start = 1;
        else m_err = 1;
      end
    end
  endtask

  task automatic drive(int gap_every, int gap_len, int nbytes);
    int n;
    int g;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_job", int'(bus.in_ready), 1);
    for (int i = 0; i < nbytes; i++) begin
      g = 0;
      if (i > 0 && gap_every > 0 && i % gap_every == 0) g = gap_len;
      else if (i > 0 && gap_every < 0 && $urandom_range(0, 5) == 0) g = int'($urandom_range(1, 3));
      repeat (g) begin
        @(posedge clk); #1;
        if (!bus.in_ready) ready_low++;
      end
      bus.in_data  = s_data[i];
      bus.in_last  = s_last[i];
      bus.in_valid = 1'b1;
      if (!bus.in_ready) ready_low++;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  function automatic int diff(wr_t a[$], wr_t b[$]);
    int d;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int k = 0; k < a.size() && k < b.size(); k++)
      if (a[k].addr != b[k].addr || a[k].data != b[k].data) d++;
    return d;
  endfunction

  function automatic int last_wr(wr_t q[$], int addr);
    int v;
    v = 'h0BAD0BAD;
    foreach (q[k]) if (q[k].addr == addr) v = int'(q[k].data);
    return v;
  endfunction

  task automatic check_job(string tag, int e_i2, int e_i1, int e_start, int e_err);
    chk({tag, "_i2_count"}, act_i2.size(), e_i2);
    chk({tag, "_i1_count"}, act_i1.size(), e_i1);
    chk({tag, "_i2_content"}, diff(act_i2, exp_i2), 0);
    chk({tag, "_i1_content"}, diff(act_i1, exp_i1), 0);
    chk({tag, "_start_pulses"}, start_cnt, e_start);
    chk({tag, "_frame_err_pulses"}, err_cnt, e_err);
    chk({tag, "_job_done_pulses"}, done_cnt, e_start);
    chk({tag, "_start_width"}, dbl_start, 0);
    chk({tag, "_ready_low_while_loading"}, ready_low, 0);
    if (e_start != 0) chk({tag, "_start_after_last_word"}, start_cyc - last_i1_cyc, 1);
    clear_mon();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_input1_wea"}, int'(bus.input1_wea), 0);
    chk({tag, "_input1_dia"}, int'(bus.input1_dia), 0);
    chk({tag, "_input1_addra"}, int'(bus.input1_addra), 0);
    chk({tag, "_input2_wea"}, int'(bus.input2_wea), 0);
    chk({tag, "_input2_dia"}, int'(bus.input2_dia), 0);
    chk({tag, "_input2_addra"}, int'(bus.input2_addra), 0);
    chk({tag, "_enc_start"}, int'(bus.enc_start), 0);
    chk({tag, "_job_done"}, int'(bus.job_done), 0);
    chk({tag, "_frame_err"}, int'(bus.frame_err), 0);
  endtask

  initial begin
    vec_t vt[8];
    int   n, hold_bad, r, bidx;

    //          gap  len  bad  omit spot  i2   i1 start err
    vt[0] = '{0, 0, -1,  0, 1, 896, 24, 1, 0};
    vt[1] = '{7, 3, -1,  0, 1, 896, 24, 1, 0};
    vt[2] = '{0, 0, 500, 0, 0, 500, 0,  0, 1};
    vt[3] = '{0, 0, -1,  0, 1, 896, 24, 1, 0};
    vt[4] = '{0, 0, -1,  1, 0, 896, 24, 0, 1};
    vt[5] = '{0, 0, 0,   0, 0, 0,   0,  0, 1};
    vt[6] = '{5, 2, 950, 0, 0, 896, 13, 0, 1};
    vt[7] = '{0, 0, 980, 0, 0, 896, 21, 0, 1};

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.enc_done = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", int'(bus.in_ready), 1);

    for (int k = 0; k < 8; k++) begin
      build(vt[k].bad_idx, vt[k].omit_last, 1'b0);
      model();
      drive(vt[k].gap_every, vt[k].gap_len, s_data.size());
      settle();
      if (vt[k].spot) begin
        chk($sformatf("row%0d_i2_addr5", k), last_wr(act_i2, 5), 'h05);
        chk($sformatf("row%0d_i1_addr8", k), last_wr(act_i1, 8), int'(32'h80818283));
        chk($sformatf("row%0d_i1_addr0", k), last_wr(act_i1, 0), int'(32'h00010203));
        chk($sformatf("row%0d_i1_addr23", k), last_wr(act_i1, 23), int'(32'hFCFDFEFF));
      end
      if (vt[k].bad_idx >= 0)
        chk($sformatf("row%0d_no_write_at_bad", k), last_wr(act_i2, vt[k].bad_idx), 'h0BAD0BAD);
      check_job($sformatf("row%0d", k), vt[k].exp_i2, vt[k].exp_i1, vt[k].exp_start, vt[k].exp_err);
    end

    // Encrypter holds done low for 50 cycles after start.
    bus.enc_done = 1'b0;
    build(-1, 1'b0, 1'b0);
    model();
    drive(0, 0, s_data.size());
    n = 0;
    while (start_cnt == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hs_start_seen", start_cnt, 1);
    chk("hs_i2_content", diff(act_i2, exp_i2), 0);
    chk("hs_i1_content", diff(act_i1, exp_i1), 0);
    hold_bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.in_ready || bus.job_done) hold_bad++;
    end
    chk("hs_wait_ready_or_done_high", hold_bad, 0);
    bus.enc_done = 1'b1;
    @(posedge clk); #1;
    chk("hs_job_done", int'(bus.job_done), 1);
    chk("hs_ready_after_done", int'(bus.in_ready), 1);
    @(negedge clk); #1;
    chk("hs_done_pulses", done_cnt, 1);
    chk("hs_start_pulses", start_cnt, 1);
    chk("hs_frame_err_pulses", err_cnt, 0);
    clear_mon();
    build(-1, 1'b0, 1'b1);
    model();
    drive(0, 0, s_data.size());
    settle();
    check_job("hs_second", POLY, 24, 1, 0);

    // Async reset in the middle of a coin word group.
    build(-1, 1'b0, 1'b0);
    drive(0, 0, POLY + SEED + 6);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    chk("ready_after_async_rst", int'(bus.in_ready), 1);
    build(-1, 1'b0, 1'b0);
    model();
    drive(0, 0, s_data.size());
    settle();
    chk("after_rst_i1_addr0", last_wr(act_i1, 0), int'(32'h00010203));
    check_job("after_rst", POLY, 24, 1, 0);

    // Random data, random gaps, random framing faults.
    for (int k = 0; k < 6; k++) begin
      r    = int'($urandom_range(0, 2));
      bidx = (r == 0) ? int'($urandom_range(0, JOB - 2)) : -1;
      build(bidx, (r == 1), 1'b1);
      model();
      drive(-1, 0, s_data.size());
      settle();
      check_job($sformatf("rnd%0d", k), exp_i2.size(), exp_i1.size(), m_start, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
